ascii_cell_sched: RTL and testbench

ASCII_CELL_SCHED -- requirements
Module: ascii_cell_sched

---
 rtl/ascii_cell_sched.sv | 125 ++++++++++++
 tb/tb_ascii_cell_sched.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ascii_cell_sched.sv
// ascii_cell_sched: reduces a streamed VGA frame to per-8x8-cell average
// intensities. One partial sum per cell column is kept across the 8 pixel
// rows of a cell row. Results go through a small FIFO to the glyph consumer.
module ascii_cell_sched #(
  parameter int H_CELLS    = 80,
  parameter int V_CELLS    = 60,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        vga_clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        video_on,
  input  logic [3:0]  pix_val,
  input  logic [11:0] pixel_row,
  input  logic [11:0] pixel_column,
  output logic        cell_valid,
  input  logic        cell_ready,
  output logic [6:0]  cell_x,
  output logic [5:0]  cell_y,
  output logic [3:0]  cell_lvl,
  output logic        frame_done,
  output logic        overrun
);

  localparam int IW = (H_CELLS > 1) ? $clog2(H_CELLS) : 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic {IDLE, ACCUM} state_e;

  typedef struct packed {
    logic [6:0] x;
    logic [5:0] y;
    logic [3:0] lvl;
  } cell_t;

  state_e        state_q, state_d;
  logic [PW:0]   wr_q, wr_d, rd_q, rd_d;
  logic          frame_done_q, frame_done_d;
  logic          overrun_q, overrun_d;
  logic [9:0]    acc_q [H_CELLS];
  cell_t         fifo_q [FIFO_DEPTH];

  logic          in_range, start, accept, cell_first, cell_last;
  logic          push, pop, full, do_push, frame_last;
  logic [IW-1:0] idx;
  logic [9:0]    sum, acc_nxt;
  logic [PW:0]   count;
  cell_t         entry, head;

  // Pixel qualification, accumulation datapath, FSM and FIFO control.
  always_comb begin
    in_range   = video_on && (pixel_column < 12'(8 * H_CELLS))
                          && (pixel_row < 12'(8 * V_CELLS));
    start      = (state_q == IDLE) && enable && in_range
                 && (pixel_row == 12'd0) && (pixel_column == 12'd0);
    accept     = in_range && ((state_q == ACCUM) || start);
    idx        = pixel_column[3 +: IW];
    cell_first = (pixel_row[2:0] == 3'd0) && (pixel_column[2:0] == 3'd0);
    cell_last  = (pixel_row[2:0] == 3'd7) && (pixel_column[2:0] == 3'd7);
    sum        = acc_q[idx] + {6'd0, pix_val};
    // First pixel of a cell discards whatever the previous cell row left.
    acc_nxt    = cell_first ? {6'd0, pix_val} : sum;

    entry.x    = pixel_column[9:3];
    entry.y    = pixel_row[8:3];
    entry.lvl  = sum[9:6];

    push       = accept && cell_last;
    frame_last = push && ((pixel_column >> 3) == 12'(H_CELLS - 1))
                      && ((pixel_row >> 3) == 12'(V_CELLS - 1));

    count      = wr_q - rd_q;
    full       = (count == (PW+1)'(FIFO_DEPTH));
    pop        = (count != '0) && cell_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still take it.
    do_push    = push && (!full || pop);

    wr_d       = do_push ? wr_q + 1'b1 : wr_q;
    rd_d       = pop ? rd_q + 1'b1 : rd_q;
    overrun_d  = overrun_q || (push && full && !pop);
    frame_done_d = frame_last;

    state_d = state_q;
    if (start)      state_d = ACCUM;
    if (frame_last) state_d = IDLE;

    head = fifo_q[rd_q[PW-1:0]];
  end

  // Control state, FIFO pointers and registered status flags.
  always_ff @(posedge vga_clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_q         <= '0;
      rd_q         <= '0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_q         <= wr_d;
      rd_q         <= rd_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
    end
  end

  // Partial sums per cell column; never reset, reloaded at each cell start.
  always_ff @(posedge vga_clk) begin
    if (accept) acc_q[idx] <= acc_nxt;
  end

  // Result storage; only the write slot is touched.
  always_ff @(posedge vga_clk) begin
    if (!rst && do_push) fifo_q[wr_q[PW-1:0]] <= entry;
  end

  // Head fields are forced to zero while empty so stale slots never leak out.
  assign cell_valid = (count != '0);
  assign cell_x     = cell_valid ? head.x   : 7'd0;
  assign cell_y     = cell_valid ? head.y   : 6'd0;
  assign cell_lvl   = cell_valid ? head.lvl : 4'd0;
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_ascii_cell_sched.sv
// Scoreboard bench for ascii_cell_sched on a reduced 4x3-cell frame.
module tb_ascii_cell_sched;
  localparam int H = 4, V = 3, D = 4, ROWS = 26, COLS = 36;

  logic        clk = 1'b0;
  logic        rst = 1'b1, enable = 1'b0, video_on = 1'b0, cell_ready = 1'b0;
  logic [3:0]  pix = '0;
  logic [11:0] prow = '0, pcol = '0;
  logic        cell_valid, frame_done, overrun;
  logic [6:0]  cell_x;
  logic [5:0]  cell_y;
  logic [3:0]  cell_lvl;

  ascii_cell_sched #(.H_CELLS(H), .V_CELLS(V), .FIFO_DEPTH(D)) dut (
    .vga_clk(clk), .rst(rst), .enable(enable), .video_on(video_on),
    .pix_val(pix), .pixel_row(prow), .pixel_column(pcol),
    .cell_valid(cell_valid), .cell_ready(cell_ready), .cell_x(cell_x),
    .cell_y(cell_y), .cell_lvl(cell_lvl), .frame_done(frame_done),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] x;
    logic [5:0] y;
    logic [3:0] l;
  } exp_t;

  exp_t q[$];
  int   tests = 0, fails = 0, fd_cnt = 0;

  task automatic chk(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int pixf(int pat, int r, int c);
    int cx, cy, li;
    cx = c / 8; cy = r / 8; li = (r % 8) * 8 + (c % 8);
    case (pat)
      0: return 15;
      1: begin
        if (cx == 0 && cy == 0) return 4;
        if (cx == 1 && cy == 0) return (li < 4) ? 15 : ((li == 4) ? 3 : 0);
        return 0;
      end
      default: return (r * 3 + c * 5 + r * c) & 15;
    endcase
  endfunction

  function automatic int exp_lvl(int pat, int cx, int cy);
    int s;
    s = 0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        s += pixf(pat, cy * 8 + r, cx * 8 + c);
    return (s / 64) & 15;
  endfunction

  // Monitor: pop and compare on every handshake, count frame_done cycles.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_done) fd_cnt++;
      if (cell_valid && cell_ready) begin
        if (q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_cell: got x=%0d y=%0d lvl=%0d, none expected",
                   cell_x, cell_y, cell_lvl);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("cell_x", int'(cell_x), int'(e.x));
          chk("cell_y", int'(cell_y), int'(e.y));
          chk("cell_lvl", int'(cell_lvl), int'(e.l));
        end
      end
    end
  end

  // Scan one full raster (with blanking and out-of-range visible pixels).
  // rmode: 0 ready high, 1 ready low, 2 ready rises with the fifth cell push.
  task automatic drive_frame(int pat, int rmode, int en_row, int rst_r, int rst_c, bit cap_init);
    bit cap;
    bit post_rst, fd_next, fd_after;
    int pushed, fd0;
    cap = cap_init; post_rst = 0; fd_next = 0; fd_after = 0; pushed = 0;
    fd0 = fd_cnt;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        @(posedge clk); #1;
        if (post_rst) begin
          chk("rst_valid", int'(cell_valid), 0);
          chk("rst_x", int'(cell_x), 0);
          chk("rst_y", int'(cell_y), 0);
          chk("rst_lvl", int'(cell_lvl), 0);
          chk("rst_overrun", int'(overrun), 0);
          chk("rst_frame_done", int'(frame_done), 0);
          post_rst = 0;
        end
        if (fd_after) begin chk("frame_done_width", int'(frame_done), 0); fd_after = 0; end
        if (fd_next) begin chk("frame_done_pulse", int'(frame_done), 1); fd_next = 0; fd_after = 1; end
        rst = (r == rst_r && c == rst_c);
        if (rst) begin cap = 0; post_rst = 1; end
        video_on = (r < 25 && c < 34);
        pix      = video_on ? 4'(pixf(pat, r, c)) : 4'd9;
        prow     = 12'(r);
        pcol     = 12'(c);
        enable   = (r >= en_row);
        case (rmode)
          0:       cell_ready = 1'b1;
          1:       cell_ready = 1'b0;
          default: cell_ready = (r > 15 || (r == 15 && c >= 7));
        endcase
        if (cap && r < 24 && c < 32 && r % 8 == 7 && c % 8 == 7) begin
          if (rmode != 1 || pushed < D)
            q.push_back('{x: 7'(c / 8), y: 6'(r / 8), l: 4'(exp_lvl(pat, c / 8, r / 8))});
          pushed++;
          if (r == 23 && c == 31) fd_next = 1;
        end
      end
    end
    @(posedge clk); #1;
    rst = 1'b0; video_on = 1'b0;
    chk("frame_done_count", fd_cnt - fd0, cap ? 1 : 0);
    if (rmode != 1) begin
      for (int i = 0; i < 40 && q.size() != 0; i++) @(posedge clk);
      chk("drain_empty", q.size(), 0);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", int'(cell_valid), 0);
    chk("reset_x", int'(cell_x), 0);
    chk("reset_y", int'(cell_y), 0);
    chk("reset_lvl", int'(cell_lvl), 0);
    chk("reset_frame_done", int'(frame_done), 0);
    chk("reset_overrun", int'(overrun), 0);
    rst = 1'b0;

    // Uniform 15, single-cell pattern, and a varied gradient.
    drive_frame(0, 0, 0, -1, -1, 1);
    drive_frame(1, 0, 0, -1, -1, 1);
    drive_frame(2, 0, 0, -1, -1, 1);

    // Consumer stalled for a whole frame: four held, rest dropped.
    drive_frame(2, 1, 0, -1, -1, 1);
    chk("ovr_set", int'(overrun), 1);
    chk("ovr_head_valid", int'(cell_valid), 1);
    chk("ovr_head_x", int'(cell_x), 0);
    chk("ovr_head_y", int'(cell_y), 0);
    chk("ovr_head_lvl", int'(cell_lvl), exp_lvl(2, 0, 0));
    cell_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    chk("ovr_drain", q.size(), 0);
    chk("ovr_empty", int'(cell_valid), 0);
    chk("ovr_sticky", int'(overrun), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("ovr_cleared", int'(overrun), 0);

    // Full FIFO with a pop coinciding with the fifth push.
    drive_frame(2, 2, 0, -1, -1, 1);
    chk("full_pop_no_overrun", int'(overrun), 0);

    // Reset mid-frame, then a clean frame.
    drive_frame(2, 0, 0, 12, 20, 1);
    drive_frame(2, 0, 0, -1, -1, 1);
    chk("post_rst_overrun", int'(overrun), 0);

    // Enable low at frame start, raised mid-frame: nothing until next frame.
    drive_frame(0, 0, 10, -1, -1, 0);
    drive_frame(1, 0, 0, -1, -1, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
